// File: rtl/alu_response_checker.sv
// rtl/alu_response_checker.sv - golden-model response checker with MISR compaction for the 4-bit ALU
module alu_response_checker #(
  parameter int unsigned NUM_VECTORS = 30,
  parameter logic [15:0] MISR_SEED   = 16'h0000,
  parameter logic [15:0] MISR_POLY   = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic [1:0]  Op,
  input  logic [3:0]  C,
  output logic        busy,
  output logic        fault_indicator,
  output logic [15:0] fault_counter,
  output logic [15:0] vector_count,
  output logic [15:0] signature,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // vector_count value held just before the final vector of a session is accepted
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  state_t      state_q, state_d;
  logic        fault_q;
  logic [15:0] fault_cnt_q;
  logic [15:0] vec_cnt_q;
  logic [15:0] sig_q;

  logic [3:0]  expect_res;
  logic        div_by_zero;
  logic        mismatch;
  logic        accept;
  logic        session_start;
  logic        last_vec;
  logic [15:0] misr_next;

  // Golden ALU model; results are naturally truncated to 4 bits
  always_comb begin
    expect_res = 4'h0;
    case (Op)
      2'b00: expect_res = A + B;
      2'b01: expect_res = A - B;
      2'b10: expect_res = A * B;
      default: expect_res = (B == 4'h0) ? 4'h0 : (A / B);
    endcase
  end

  assign div_by_zero   = (Op == 2'b11) && (B == 4'h0);
  assign mismatch      = !div_by_zero && (C != expect_res);
  assign accept        = (state_q == S_RUN) && in_valid;
  // start only matters outside RUN; a pulse during RUN is ignored
  assign session_start = (state_q != S_RUN) && start;
  assign last_vec      = accept && (vec_cnt_q == LAST_IDX);
  assign misr_next     = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                         ^ {12'h000, C};

  // Session state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Session next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (last_vec) state_d = S_DONE;
      S_DONE:  if (start)    state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-vector fault flag, saturating fault count, vector count and MISR signature
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q     <= 1'b0;
      fault_cnt_q <= 16'h0000;
      vec_cnt_q   <= 16'h0000;
      sig_q       <= MISR_SEED;
    end else if (session_start) begin
      fault_q     <= 1'b0;
      fault_cnt_q <= 16'h0000;
      vec_cnt_q   <= 16'h0000;
      sig_q       <= MISR_SEED;
    end else if (accept) begin
      fault_q   <= mismatch;
      vec_cnt_q <= vec_cnt_q + 16'h0001;
      sig_q     <= misr_next;
      if (mismatch && (fault_cnt_q != 16'hFFFF))
        fault_cnt_q <= fault_cnt_q + 16'h0001;
    end
  end

  // Status outputs decoded from the session state
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (fault_cnt_q == 16'h0000);
  end

  assign fault_indicator = fault_q;
  assign fault_counter   = fault_cnt_q;
  assign vector_count    = vec_cnt_q;
  assign signature       = sig_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// tb/tb_alu_response_checker.sv - directed-vector bench for alu_response_checker
module tb_alu_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] A, B, C;
  logic [1:0] Op;

  logic        busy2, fi2, done2, pass2;
  logic [15:0] fc2, vc2, sig2;
  logic        busy30, fi30, done30, pass30;
  logic [15:0] fc30, vc30, sig30;
  logic        busys, fis, dones, passs;
  logic [15:0] fcs, vcs, sigs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_response_checker #(.NUM_VECTORS(2)) u_two (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .Op(Op), .C(C),
    .busy(busy2), .fault_indicator(fi2), .fault_counter(fc2),
    .vector_count(vc2), .signature(sig2), .done(done2), .pass(pass2)
  );

  alu_response_checker #(.NUM_VECTORS(30)) u_thirty (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .Op(Op), .C(C),
    .busy(busy30), .fault_indicator(fi30), .fault_counter(fc30),
    .vector_count(vc30), .signature(sig30), .done(done30), .pass(pass30)
  );

  alu_response_checker #(.NUM_VECTORS(65535)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .Op(Op), .C(C),
    .busy(busys), .fault_indicator(fis), .fault_counter(fcs),
    .vector_count(vcs), .signature(sigs), .done(dones), .pass(passs)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vec(input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] op, input logic [3:0] c);
    A = a; B = b; Op = op; C = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    A = 4'h0; B = 4'h0; Op = 2'b00; C = 4'h0;
    #2;

    // Reset state
    do_reset();
    chk("rst_busy", {15'b0, busy2}, 16'h0000);
    chk("rst_done", {15'b0, done2}, 16'h0000);
    chk("rst_pass", {15'b0, pass2}, 16'h0000);
    chk("rst_fi",   {15'b0, fi2},   16'h0000);
    chk("rst_fc",   fc2,  16'h0000);
    chk("rst_vc",   vc2,  16'h0000);
    chk("rst_sig",  sig2, 16'h0000);

    // In IDLE, in_valid is ignored
    vec(4'h1, 4'h1, 2'b00, 4'h0);
    chk("idle_vc", vc2, 16'h0000);

    // Test 1: two matching adds, 1+4=5
    do_start();
    chk("t1_busy", {15'b0, busy2}, 16'h0001);
    vec(4'h1, 4'h4, 2'b00, 4'h5);
    chk("t1_fi1",  {15'b0, fi2}, 16'h0000);
    chk("t1_sig1", sig2, 16'h0005);
    chk("t1_done_early", {15'b0, done2}, 16'h0000);
    vec(4'h1, 4'h4, 2'b00, 4'h5);
    chk("t1_sig2", sig2, 16'h000F);
    chk("t1_vc2",  vc2,  16'h0002);
    chk("t1_done", {15'b0, done2}, 16'h0001);
    chk("t1_pass", {15'b0, pass2}, 16'h0001);
    chk("t1_busy_done", {15'b0, busy2}, 16'h0000);

    // Test 2: sub wraps (match), mul 15 vs 0 (mismatch); start from DONE
    do_start();
    chk("t2_done_drop", {15'b0, done2}, 16'h0000);
    chk("t2_vc_clr", vc2, 16'h0000);
    vec(4'h3, 4'h5, 2'b01, 4'hE);
    chk("t2_fi1",  {15'b0, fi2}, 16'h0000);
    chk("t2_sig1", sig2, 16'h000E);
    vec(4'h3, 4'h5, 2'b10, 4'h0);
    chk("t2_fi2",  {15'b0, fi2}, 16'h0001);
    chk("t2_fc2",  fc2,  16'h0001);
    chk("t2_sig2", sig2, 16'h001C);
    chk("t2_done", {15'b0, done2}, 16'h0001);
    chk("t2_pass", {15'b0, pass2}, 16'h0000);

    // Test 3: faulty add then div by zero
    do_start();
    chk("t3_fc_clr", fc2, 16'h0000);
    chk("t3_fi_clr", {15'b0, fi2}, 16'h0000);
    vec(4'h1, 4'h1, 2'b00, 4'h0);
    chk("t3_fi1", {15'b0, fi2}, 16'h0001);
    chk("t3_fc1", fc2, 16'h0001);
    vec(4'h7, 4'h0, 2'b11, 4'h3);
    chk("t3_fi_dz",  {15'b0, fi2}, 16'h0000);
    chk("t3_fc_dz",  fc2,  16'h0001);
    chk("t3_vc_dz",  vc2,  16'h0002);
    chk("t3_sig_dz", sig2, 16'h0003);

    // Test 4: reset mid-session after 5 faulty vectors (2+2 expects 4, C=1)
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) vec(4'h2, 4'h2, 2'b00, 4'h1);
    chk("t4_vc5",  vc30,  16'h0005);
    chk("t4_fc5",  fc30,  16'h0005);
    chk("t4_sig5", sig30, 16'h001F);
    chk("t4_div_ok_unused", {15'b0, fi30}, 16'h0001);
    do_reset();
    chk("t4_busy", {15'b0, busy30}, 16'h0000);
    chk("t4_vc",   vc30,  16'h0000);
    chk("t4_fc",   fc30,  16'h0000);
    chk("t4_fi",   {15'b0, fi30}, 16'h0000);
    chk("t4_sig",  sig30, 16'h0000);
    vec(4'h2, 4'h2, 2'b00, 4'h1);
    vec(4'h2, 4'h2, 2'b00, 4'h1);
    chk("t4_idle_vc", vc30, 16'h0000);
    chk("t4_idle_fc", fc30, 16'h0000);

    // Test 5: gaps, start during RUN, DONE hold, restart from DONE (9/3=3 matches)
    do_start();
    for (int i = 0; i < 3; i++) vec(4'h9, 4'h3, 2'b11, 4'h3);
    tick();
    tick();
    chk("t5_gap_vc", vc30, 16'h0003);
    do_start();
    chk("t5_start_run_busy", {15'b0, busy30}, 16'h0001);
    chk("t5_start_run_vc",   vc30, 16'h0003);
    start = 1'b1;
    vec(4'h9, 4'h3, 2'b11, 4'h3);
    start = 1'b0;
    chk("t5_start_vec_vc", vc30, 16'h0004);
    for (int i = 0; i < 25; i++) vec(4'h9, 4'h3, 2'b11, 4'h3);
    chk("t5_vc29",  vc30, 16'd29);
    chk("t5_busy29", {15'b0, busy30}, 16'h0001);
    vec(4'h9, 4'h3, 2'b11, 4'h3);
    chk("t5_vc30",  vc30, 16'd30);
    chk("t5_done",  {15'b0, done30}, 16'h0001);
    chk("t5_pass",  {15'b0, pass30}, 16'h0001);
    vec(4'h9, 4'h3, 2'b11, 4'h0);
    chk("t5_done_hold_vc", vc30, 16'd30);
    chk("t5_done_hold_fc", fc30, 16'h0000);
    do_start();
    chk("t5_restart_busy", {15'b0, busy30}, 16'h0001);
    chk("t5_restart_done", {15'b0, done30}, 16'h0000);
    chk("t5_restart_vc",   vc30, 16'h0000);

    // Test 6: 65535 faulty vectors (0+0 expects 0, C=1) saturate the count
    do_reset();
    chk("t6_rst_busy", {15'b0, busys}, 16'h0000);
    do_start();
    A = 4'h0; B = 4'h0; Op = 2'b00; C = 4'h1;
    in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("t6_fc_pre",   fcs, 16'hFFFE);
    chk("t6_busy_pre", {15'b0, busys}, 16'h0001);
    tick();
    chk("t6_fc_sat", fcs, 16'hFFFF);
    chk("t6_vc",     vcs, 16'hFFFF);
    chk("t6_done",   {15'b0, dones}, 16'h0001);
    chk("t6_pass",   {15'b0, passs}, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("t6_fc_hold", fcs, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
